vmem_reader: RTL and testbench

- Read-side initiator for the vmem small-memory interface (addr/ren/odata).
- Accepts read requests on a valid/ready port and issues registered `ren`/`addr` to the memory.
- Tracks in-flight reads through a fixed memory read latency and returns data plus address on a valid/ready response port, with credit-based backpressure so no read data is ever dropped.
- Sits between a client (decoder/sequencer or bench) and the vmem array, mirroring the write path.

---
 rtl/vmem_pkg.sv | 28 ++
 rtl/vmem_rsp_fifo.sv | 66 ++++++
 rtl/vmem_reader.sv | 115 +++++++++++
 tb/tb_vmem_reader.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vmem_pkg.sv
// Shared types and helpers for the vmem read/write initiators.
package vmem_pkg;

  localparam int VMEM_AW = 4;
  localparam int VMEM_DW = 8;

  typedef logic [VMEM_AW-1:0] vmem_addr_t;
  typedef logic [VMEM_DW-1:0] vmem_data_t;

  typedef struct packed {
    vmem_addr_t addr;
    vmem_data_t data;
  } vmem_rsp_t;

  // Bits needed to index `value` distinct items; returns 0 for value <= 1.
  function automatic int clog2(input int value);
    int result;
    int v;
    result = 0;
    v = value - 1;
    while (v > 0) begin
      result = result + 1;
      v = v >> 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/vmem_rsp_fifo.sv
// In-order response buffer for vmem reads; any depth >= 1, including non-powers of two.
module vmem_rsp_fifo
  import vmem_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int CW = clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  vmem_rsp_t     push_data,
  input  logic          pop,
  output vmem_rsp_t     head,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);

  localparam int PW = (DEPTH > 1) ? clog2(DEPTH) : 1;

  vmem_rsp_t     store [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] cnt;
  logic          do_pop;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign do_pop = pop && !empty;
  assign empty  = (cnt == '0);
  assign full   = (cnt == CW'(DEPTH));
  assign count  = cnt;
  assign head   = store[rd_ptr];

  always_ff @(posedge clk) begin
    if (push) begin
      store[wr_ptr] <= push_data;
    end
  end

  // Pointers wrap explicitly so that non-power-of-two depths work.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push) begin
        wr_ptr <= next_ptr(wr_ptr);
      end
      if (do_pop) begin
        rd_ptr <= next_ptr(rd_ptr);
      end
      case ({push, do_pop})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  a_no_push_full: assert property (@(posedge clk) disable iff (rst) !(push && full));

endmodule

// File: rtl/vmem_reader.sv
// Read-side initiator for the vmem array: issues registered reads, tracks them through
// the fixed read latency and buffers results behind a credit counter so data is never dropped.
module vmem_reader
  import vmem_pkg::*;
#(
  parameter int AW        = VMEM_AW,
  parameter int DW        = VMEM_DW,
  parameter int RD_LAT    = 1,
  parameter int RSP_DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic [AW-1:0] req_addr,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [DW-1:0] rsp_data,
  output logic [AW-1:0] rsp_addr,
  output logic          mem_ren,
  output logic [AW-1:0] mem_addr,
  input  logic [DW-1:0] mem_odata,
  output logic          busy
);

  localparam int CW = clog2(RSP_DEPTH + 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(RSP_DEPTH);

  logic [CW-1:0]     pending;
  logic              accept;
  logic              pop;
  logic [RD_LAT-1:0] tag_valid;
  vmem_addr_t        tag_addr [RD_LAT];
  vmem_rsp_t         push_data;
  vmem_rsp_t         head;
  logic              fifo_full;
  logic              fifo_empty;
  logic [CW-1:0]     fifo_count;

  // Credit decision uses only registered state, so rsp_ready never reaches req_ready.
  assign req_ready = (pending < DEPTH_C);
  assign busy      = (pending != '0);
  assign accept    = req_valid && req_ready;
  assign pop       = rsp_valid && rsp_ready;

  assign rsp_valid = !fifo_empty;
  assign rsp_data  = fifo_empty ? '0 : head.data;
  assign rsp_addr  = fifo_empty ? '0 : head.addr;

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_ren  <= 1'b0;
      mem_addr <= '0;
    end else begin
      mem_ren <= accept;
      if (accept) begin
        mem_addr <= req_addr;
      end
    end
  end

  // The tag leaves the pipe in exactly the cycle mem_odata holds its data.
  always_ff @(posedge clk) begin
    if (rst) begin
      tag_valid <= '0;
    end else begin
      tag_valid[0] <= mem_ren;
      for (int i = 1; i < RD_LAT; i++) begin
        tag_valid[i] <= tag_valid[i-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    tag_addr[0] <= mem_addr;
    for (int i = 1; i < RD_LAT; i++) begin
      tag_addr[i] <= tag_addr[i-1];
    end
  end

  assign push_data.addr = tag_addr[RD_LAT-1];
  assign push_data.data = mem_odata;

  vmem_rsp_fifo #(.DEPTH(RSP_DEPTH)) u_rsp_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (tag_valid[RD_LAT-1]),
    .push_data (push_data),
    .pop       (pop),
    .head      (head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      pending <= '0;
    end else begin
      case ({accept, pop})
        2'b10:   pending <= pending + CW'(1);
        2'b01:   pending <= pending - CW'(1);
        default: pending <= pending;
      endcase
    end
  end

  a_pending_max: assert property (@(posedge clk) disable iff (rst) pending <= DEPTH_C);
  a_count_le_pending: assert property (@(posedge clk) disable iff (rst) fifo_count <= pending);
  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(tag_valid[RD_LAT-1] && fifo_full));
  a_rsp_stable: assert property (@(posedge clk) disable iff (rst)
    (rsp_valid && !rsp_ready) |=> (rsp_valid && $stable(rsp_data) && $stable(rsp_addr)));

endmodule

// File: tb/tb_vmem_reader.sv
// Drives two vmem_reader configurations (RD_LAT=1/RSP_DEPTH=4 and RD_LAT=3/RSP_DEPTH=6)
// with shared stimulus and checks both against a transaction-level model every cycle.
module tb_vmem_reader;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req_valid = 1'b0;
  logic [3:0] req_addr = '0;
  logic       rsp_ready = 1'b0;

  logic       req_ready_w [2];
  logic       rsp_valid_w [2];
  logic       mem_ren_w   [2];
  logic       busy_w      [2];
  logic [7:0] rsp_data_w  [2];
  logic [7:0] mem_odata_w [2];
  logic [3:0] rsp_addr_w  [2];
  logic [3:0] mem_addr_w  [2];

  logic [7:0] mem [16];
  logic [7:0] mp  [2][3];

  int checks = 0;
  int failures = 0;

  int         cyc = 0;
  bit         armed = 0;
  int         pend      [2];
  int         qh        [2];
  int         qn        [2];
  logic [3:0] qa        [2][8];
  int         qt        [2][8];
  bit         last_acc  [2];
  logic [3:0] last_addr [2];
  int         acc_cnt   [2];
  int         pop_cnt   [2];

  always #5 clk = ~clk;

  vmem_reader #(.AW(4), .DW(8), .RD_LAT(1), .RSP_DEPTH(4)) dut0 (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready_w[0]),
    .req_addr(req_addr), .rsp_valid(rsp_valid_w[0]), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data_w[0]), .rsp_addr(rsp_addr_w[0]), .mem_ren(mem_ren_w[0]),
    .mem_addr(mem_addr_w[0]), .mem_odata(mem_odata_w[0]), .busy(busy_w[0])
  );

  vmem_reader #(.AW(4), .DW(8), .RD_LAT(3), .RSP_DEPTH(6)) dut1 (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready_w[1]),
    .req_addr(req_addr), .rsp_valid(rsp_valid_w[1]), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data_w[1]), .rsp_addr(rsp_addr_w[1]), .mem_ren(mem_ren_w[1]),
    .mem_addr(mem_addr_w[1]), .mem_odata(mem_odata_w[1]), .busy(busy_w[1])
  );

  // Memory array with a read pipe; each DUT taps the stage matching its latency.
  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      mp[k][0] <= mem[mem_addr_w[k]];
      mp[k][1] <= mp[k][0];
      mp[k][2] <= mp[k][1];
    end
  end
  assign mem_odata_w[0] = mp[0][0];
  assign mem_odata_w[1] = mp[1][2];

  function automatic int lat_of(input int k);
    return (k == 0) ? 1 : 3;
  endfunction

  function automatic int dep_of(input int k);
    return (k == 0) ? 4 : 6;
  endfunction

  task automatic checkOutput(input string name, input int k, input logic [31:0] act,
                             input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s dut%0d: got 0x%0h expected 0x%0h (cycle %0d)",
               name, k, act, exp, cyc);
    end
  endtask

  // Transaction model: each accepted read becomes visible RD_LAT+2 cycles later,
  // in order, and stays at the head until popped; credits count everything in flight.
  always @(negedge clk) begin
    cyc++;
    for (int k = 0; k < 2; k++) begin : model_step
      bit er;
      bit ev;
      bit acc;
      bit pp;
      er = (pend[k] < dep_of(k));
      ev = (qn[k] > 0) && (qt[k][qh[k]] <= cyc);
      if (armed) begin
        checkOutput("req_ready", k, 32'(req_ready_w[k]), 32'(er));
        checkOutput("busy", k, 32'(busy_w[k]), 32'(pend[k] != 0));
        checkOutput("rsp_valid", k, 32'(rsp_valid_w[k]), 32'(ev));
        checkOutput("mem_ren", k, 32'(mem_ren_w[k]), 32'(last_acc[k]));
        if (last_acc[k]) checkOutput("mem_addr", k, 32'(mem_addr_w[k]), 32'(last_addr[k]));
        if (ev) begin
          checkOutput("rsp_addr", k, 32'(rsp_addr_w[k]), 32'(qa[k][qh[k]]));
          checkOutput("rsp_data", k, 32'(rsp_data_w[k]), 32'(mem[qa[k][qh[k]]]));
        end
      end
      if (rst) begin
        pend[k] = 0;
        qh[k] = 0;
        qn[k] = 0;
        last_acc[k] = 0;
        last_addr[k] = '0;
      end else begin
        acc = req_valid && er;
        pp = ev && rsp_ready;
        if (pp) begin
          qh[k] = (qh[k] + 1) % 8;
          qn[k]--;
          pop_cnt[k]++;
        end
        if (acc) begin
          qa[k][(qh[k] + qn[k]) % 8] = req_addr;
          qt[k][(qh[k] + qn[k]) % 8] = cyc + lat_of(k) + 2;
          qn[k]++;
          acc_cnt[k]++;
        end
        pend[k] = pend[k] + int'(acc) - int'(pp);
        last_acc[k] = acc;
        if (acc) last_addr[k] = req_addr;
      end
    end
    if (rst) armed = 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input bit v, input logic [3:0] a, input bit r);
    req_valid = v;
    req_addr  = a;
    rsp_ready = r;
    tick();
  endtask

  task automatic waitIdle();
    bit done;
    done = 0;
    req_valid = 0;
    rsp_ready = 1;
    for (int i = 0; i < 60 && !done; i++) begin
      if (!busy_w[0] && !busy_w[1] && !rsp_valid_w[0] && !rsp_valid_w[1]) done = 1;
      else tick();
    end
    checkOutput("idle_timeout", 0, 32'(done), 32'd1);
  endtask

  initial begin
    int p0, p1, a0, a1;
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int p0, p1, a0, a1;
    for (int i = 0; i < 16; i++) mem[i] = 8'(i * 17);
    mem[5] = 8'hA5;

    rst = 1;
    tick();
    tick();
    rst = 0;
    for (int k = 0; k < 2; k++) begin
      checkOutput("rst_rsp_valid", k, 32'(rsp_valid_w[k]), 32'd0);
      checkOutput("rst_busy", k, 32'(busy_w[k]), 32'd0);
      checkOutput("rst_req_ready", k, 32'(req_ready_w[k]), 32'd1);
      checkOutput("rst_mem_ren", k, 32'(mem_ren_w[k]), 32'd0);
      checkOutput("rst_mem_addr", k, 32'(mem_addr_w[k]), 32'd0);
      checkOutput("rst_rsp_data", k, 32'(rsp_data_w[k]), 32'd0);
      checkOutput("rst_rsp_addr", k, 32'(rsp_addr_w[k]), 32'd0);
    end

    // Single read of addr 5: issue in T+1, response in T+3 (T+5 for RD_LAT=3).
    applyStimulus(1, 4'd5, 1);
    checkOutput("single_mem_ren", 0, 32'(mem_ren_w[0]), 32'd1);
    checkOutput("single_mem_addr", 0, 32'(mem_addr_w[0]), 32'd5);
    applyStimulus(0, 4'd0, 1);
    checkOutput("single_early", 0, 32'(rsp_valid_w[0]), 32'd0);
    applyStimulus(0, 4'd0, 1);
    checkOutput("single_valid", 0, 32'(rsp_valid_w[0]), 32'd1);
    checkOutput("single_data", 0, 32'(rsp_data_w[0]), 32'hA5);
    checkOutput("single_addr", 0, 32'(rsp_addr_w[0]), 32'd5);
    applyStimulus(0, 4'd0, 1);
    checkOutput("single_once", 0, 32'(rsp_valid_w[0]), 32'd0);
    checkOutput("single_busy", 0, 32'(busy_w[0]), 32'd0);
    checkOutput("lat3_early", 1, 32'(rsp_valid_w[1]), 32'd0);
    applyStimulus(0, 4'd0, 1);
    checkOutput("lat3_valid", 1, 32'(rsp_valid_w[1]), 32'd1);
    checkOutput("lat3_data", 1, 32'(rsp_data_w[1]), 32'hA5);
    waitIdle();
    mem[5] = 8'h55;

    // Streaming 16 back-to-back reads.
    p0 = pop_cnt[0];
    p1 = pop_cnt[1];
    for (int i = 0; i < 16; i++) begin
      applyStimulus(1, 4'(i), 1);
      checkOutput("stream_ready0", 0, 32'(req_ready_w[0]), 32'd1);
      checkOutput("stream_ready1", 1, 32'(req_ready_w[1]), 32'd1);
    end
    waitIdle();
    checkOutput("stream_count", 0, 32'(pop_cnt[0] - p0), 32'd16);
    checkOutput("stream_count", 1, 32'(pop_cnt[1] - p1), 32'd16);

    // Backpressure: 6 offered with rsp_ready low.
    a0 = acc_cnt[0];
    a1 = acc_cnt[1];
    p0 = pop_cnt[0];
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1, 4'(8 + i), 0);
      if (i == 3) checkOutput("bp_ready_low", 0, 32'(req_ready_w[0]), 32'd0);
    end
    checkOutput("bp_accepts", 0, 32'(acc_cnt[0] - a0), 32'd4);
    checkOutput("bp_accepts", 1, 32'(acc_cnt[1] - a1), 32'd6);
    for (int i = 0; i < 4; i++) applyStimulus(0, 4'd0, 0);
    checkOutput("bp_head_addr", 0, 32'(rsp_addr_w[0]), 32'd8);
    checkOutput("bp_head_data", 0, 32'(rsp_data_w[0]), 32'h88);
    waitIdle();
    checkOutput("bp_drained", 0, 32'(pop_cnt[0] - p0), 32'd4);
    checkOutput("bp_reopen", 0, 32'(req_ready_w[0]), 32'd1);

    // Simultaneous accept/pop at full credit.
    for (int i = 0; i < 4; i++) applyStimulus(1, 4'(i), 0);
    for (int i = 0; i < 3; i++) applyStimulus(0, 4'd0, 0);
    checkOutput("sim_full", 0, 32'(req_ready_w[0]), 32'd0);
    applyStimulus(0, 4'd0, 1);
    checkOutput("sim_pop_only", 0, 32'(req_ready_w[0]), 32'd1);
    applyStimulus(1, 4'd9, 1);
    checkOutput("sim_pop_accept", 0, 32'(req_ready_w[0]), 32'd1);
    applyStimulus(1, 4'd10, 0);
    checkOutput("sim_refill", 0, 32'(req_ready_w[0]), 32'd0);
    waitIdle();

    // Reset one cycle before the first response would appear.
    p0 = pop_cnt[0];
    p1 = pop_cnt[1];
    applyStimulus(1, 4'd1, 1);
    applyStimulus(1, 4'd2, 1);
    rst = 1;
    applyStimulus(1, 4'd3, 1);
    rst = 0;
    for (int i = 0; i < 5; i++) begin
      checkOutput("rstmid_valid", 0, 32'(rsp_valid_w[0]), 32'd0);
      checkOutput("rstmid_valid", 1, 32'(rsp_valid_w[1]), 32'd0);
      checkOutput("rstmid_busy", 0, 32'(busy_w[0]), 32'd0);
      checkOutput("rstmid_ready", 0, 32'(req_ready_w[0]), 32'd1);
      applyStimulus(0, 4'd0, 1);
    end
    applyStimulus(1, 4'd7, 1);
    applyStimulus(0, 4'd0, 1);
    applyStimulus(0, 4'd0, 1);
    checkOutput("rstmid_data", 0, 32'(rsp_data_w[0]), 32'h77);
    checkOutput("rstmid_addr", 0, 32'(rsp_addr_w[0]), 32'd7);
    waitIdle();
    checkOutput("rstmid_count", 0, 32'(pop_cnt[0] - p0), 32'd1);
    checkOutput("rstmid_count", 1, 32'(pop_cnt[1] - p1), 32'd1);

    // Random traffic with occasional resets.
    for (int n = 0; n < 400; n++) begin
      rst = ($urandom_range(0, 99) == 0);
      applyStimulus(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
                    ($urandom_range(0, 3) != 0));
    end
    rst = 0;
    waitIdle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
